// File: rtl/bus_driver_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus driven by '241/'244-style buffers.
// Each owner change passes through a dead period (TURN cycles) so that two drivers are never
// enabled together. A tenure is capped at MAXHOLD cycles while another driver is waiting.
module bus_driver_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAXHOLD = 4,
  parameter int unsigned TURN    = 1,
  parameter int unsigned IW      = 2
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] oe_,
  output logic [IW-1:0]   owner,
  output logic            busy_own,
  output logic            turn
);

  localparam int unsigned HW       = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam logic [HW-1:0] HoldMax  = HW'(MAXHOLD - 1);
  localparam logic [1:0]    TurnLast = 2'(TURN - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] oe_q;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      tcnt_q, tcnt_d;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  int unsigned     idx;
  logic            own_req;
  logic            others;

  // Rotating priority search starting one past the last owner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx  = (32'(last_q) + 32'd1 + i) % NREQ;
      cand = IW'(idx);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign own_req = |(req & grant_q);
  // grant_q is the owner's one-hot, so masking it leaves only the waiting drivers.
  assign others  = |(req & ~grant_q);

  // Next-state logic for the IDLE / OWN / TURN controller.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StOwn;
          grant_d = NREQ'(1) << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
          hold_d  = '0;
        end
      end
      StOwn: begin
        if (!own_req) begin
          // Release wins over a coincident preemption.
          grant_d = '0;
          hold_d  = '0;
          tcnt_d  = '0;
          state_d = others ? StTurn : StIdle;
        end else if (hold_q == HoldMax) begin
          hold_d = '0;
          if (others) begin
            grant_d = '0;
            tcnt_d  = '0;
            state_d = StTurn;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StTurn: begin
        if (tcnt_q == TurnLast) begin
          // last_q still holds the previous owner, giving it lowest priority here.
          if (win_valid) begin
            state_d = StOwn;
            grant_d = NREQ'(1) << win_idx;
            owner_d = win_idx;
            last_d  = win_idx;
            hold_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset floats every driver immediately without a turnaround.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      grant_q <= '0;
      oe_q    <= '1;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      hold_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      oe_q    <= ~grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign grant    = grant_q;
  assign oe_      = oe_q;
  assign owner    = owner_q;
  assign busy_own = (state_q == StOwn);
  assign turn     = (state_q == StTurn);

endmodule

// File: tb/tb_bus_driver_arbiter.sv
// Directed bench for bus_driver_arbiter: a TURN=1 instance for most scenarios and a
// TURN=2 instance for the longer dead period.
module tb_bus_driver_arbiter;

  logic       clk = 1'b0;
  logic       rst_;
  logic [3:0] req;
  logic [3:0] grant, oe_;
  logic [1:0] owner;
  logic       busy_own, turn;

  logic       rst2_;
  logic [3:0] req2;
  logic [3:0] grant2, oe2_;
  logic [1:0] owner2;
  logic       busy_own2, turn2;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_g [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
  logic       exp_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  bus_driver_arbiter #(.NREQ(4), .MAXHOLD(4), .TURN(1), .IW(2)) dut (
    .clk(clk), .rst_(rst_), .req(req), .grant(grant), .oe_(oe_), .owner(owner),
    .busy_own(busy_own), .turn(turn)
  );

  bus_driver_arbiter #(.NREQ(4), .MAXHOLD(4), .TURN(2), .IW(2)) dut2 (
    .clk(clk), .rst_(rst2_), .req(req2), .grant(grant2), .oe_(oe2_), .owner(owner2),
    .busy_own(busy_own2), .turn(turn2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    req  = 4'b1111;
    tick();
    tick();
    checks++;
    if (oe_ !== 4'b1111) begin
      failures++; $display("FAIL reset_oe got=%b want=1111", oe_);
    end
    checks++;
    if (grant !== 4'b0000 || busy_own !== 1'b0 || turn !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got grant=%b busy=%b turn=%b owner=%0d want 0000/0/0/0",
               grant, busy_own, turn, owner);
    end
    rst_ = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0 || busy_own !== 1'b1 || oe_ !== 4'b1110) begin
      failures++;
      $display("FAIL reset_first_grant got grant=%b owner=%0d busy=%b oe=%b want 0001/0/1/1110",
               grant, owner, busy_own, oe_);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy_own !== 1'b0 || turn !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got grant=%b busy=%b turn=%b want 0000/0/0",
               grant, busy_own, turn);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || busy_own !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got grant=%b owner=%0d busy=%b want 0100/2/1",
               grant, owner, busy_own);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || turn !== 1'b0) begin
        failures++;
        $display("FAIL single_hold[%0d] got grant=%b turn=%b want 0100/0", i, grant, turn);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy_own !== 1'b0 || turn !== 1'b0 || oe_ !== 4'b1111) begin
      failures++;
      $display("FAIL single_drop got grant=%b busy=%b turn=%b oe=%b want 0000/0/0/1111",
               grant, busy_own, turn, oe_);
    end
  endtask

  task automatic test_preempt();
    req = 4'b0011;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (grant !== exp_g[i] || turn !== exp_t[i] || oe_ !== ~exp_g[i]) begin
        failures++;
        $display("FAIL preempt[%0d] got grant=%b turn=%b oe=%b want grant=%b turn=%b",
                 i, grant, turn, oe_, exp_g[i], exp_t[i]);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy_own !== 1'b0 || turn !== 1'b0) begin
      failures++;
      $display("FAIL preempt_idle got grant=%b busy=%b turn=%b want 0000/0/0",
               grant, busy_own, turn);
    end
  endtask

  task automatic test_release_handoff();
    req = 4'b0001;
    tick();
    req = 4'b0101;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL handoff_own got=%b want=0001", grant);
    end
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0000 || turn !== 1'b1 || busy_own !== 1'b0) begin
      failures++;
      $display("FAIL handoff_turn got grant=%b turn=%b busy=%b want 0000/1/0",
               grant, turn, busy_own);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || turn !== 1'b0) begin
      failures++;
      $display("FAIL handoff_new got grant=%b owner=%0d turn=%b want 0100/2/0",
               grant, owner, turn);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap_late();
    rst_ = 1'b0;
    req  = 4'b0000;
    tick();
    rst_ = 1'b1;
    req  = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      failures++; $display("FAIL wrap_owner3 got grant=%b owner=%0d want 1000/3", grant, owner);
    end
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0000 || turn !== 1'b1) begin
      failures++; $display("FAIL wrap_turn got grant=%b turn=%b want 0000/1", grant, turn);
    end
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0 || turn !== 1'b0) begin
      failures++;
      $display("FAIL wrap_late got grant=%b owner=%0d turn=%b want 0001/0/0", grant, owner, turn);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_turn2();
    rst2_ = 1'b1;
    req2  = 4'b1000;
    tick();
    checks++;
    if (grant2 !== 4'b1000 || owner2 !== 2'd3) begin
      failures++; $display("FAIL turn2_owner3 got grant=%b owner=%0d want 1000/3", grant2, owner2);
    end
    req2 = 4'b0010;
    tick();
    checks++;
    if (grant2 !== 4'b0000 || turn2 !== 1'b1) begin
      failures++; $display("FAIL turn2_dead1 got grant=%b turn=%b want 0000/1", grant2, turn2);
    end
    req2 = 4'b1001;
    tick();
    checks++;
    if (grant2 !== 4'b0000 || turn2 !== 1'b1) begin
      failures++; $display("FAIL turn2_dead2 got grant=%b turn=%b want 0000/1", grant2, turn2);
    end
    tick();
    checks++;
    if (grant2 !== 4'b0001 || turn2 !== 1'b0 || busy_own2 !== 1'b1) begin
      failures++;
      $display("FAIL turn2_new got grant=%b turn=%b busy=%b want 0001/0/1",
               grant2, turn2, busy_own2);
    end
    req2 = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || oe_ !== 4'b1101) begin
      failures++; $display("FAIL async_pre got grant=%b oe=%b want 0010/1101", grant, oe_);
    end
    #2;
    rst_ = 1'b0;
    #1;
    checks++;
    if (oe_ !== 4'b1111 || grant !== 4'b0000 || busy_own !== 1'b0 || turn !== 1'b0) begin
      failures++;
      $display("FAIL async_mid got oe=%b grant=%b busy=%b turn=%b want 1111/0000/0/0",
               oe_, grant, busy_own, turn);
    end
    req = 4'b0011;
    tick();
    rst_ = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      failures++; $display("FAIL async_restart got grant=%b owner=%0d want 0001/0", grant, owner);
    end
  endtask

  initial begin
    rst2_ = 1'b0;
    req2  = 4'b0000;
    test_reset();
    test_single();
    test_preempt();
    test_release_handoff();
    test_wrap_late();
    test_turn2();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
